// File: rtl/gpio_led_sequencer_if.sv
// gpio_led_sequencer_if: configuration, trigger and output words of gpio_led_sequencer.
interface gpio_led_sequencer_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int PRESCALE_WIDTH = 32
);
    logic                      cfg_valid;
    logic [1:0]                cfg_mode;
    logic [PRESCALE_WIDTH-1:0] cfg_period;
    logic [DATA_WIDTH-1:0]     cfg_pattern;
    logic [15:0]               cfg_pulse_len;
    logic                      trig_in;
    logic [DATA_WIDTH-1:0]     led_out;
    logic [DATA_WIDTH-1:0]     exp_out;
    logic                      busy;
    modport master (
        output cfg_valid, cfg_mode, cfg_period, cfg_pattern, cfg_pulse_len, trig_in,
        input  led_out, exp_out, busy
    );
    modport slave (
        input  cfg_valid, cfg_mode, cfg_period, cfg_pattern, cfg_pulse_len, trig_in,
        output led_out, exp_out, busy
    );
endinterface

// File: rtl/gpio_led_sequencer.sv
// gpio_led_sequencer: prescaled LED pattern generator with one-shot pulse and step strobe.
module gpio_led_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int PRESCALE_WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst,
    gpio_led_sequencer_if.slave bus
);
    typedef enum logic {IDLE, PULSE} state_t;
    state_t                    state, state_nx;
    logic [15:0]               pcnt, pcnt_nx;
    logic [1:0]                mode_r;
    logic [PRESCALE_WIDTH-1:0] period_r, cnt;
    logic [DATA_WIDTH-1:0]     pattern_r, led_r, led_step;
    logic                      phase, trig_d, tick, tick_r, start;

    assign tick = cnt == period_r;
    assign start = bus.trig_in & ~trig_d & (bus.cfg_pulse_len != 16'd0);
    assign led_step = mode_r == 2'd0 ? pattern_r :
                      mode_r == 2'd1 ? (phase ? '0 : pattern_r) :
                      mode_r == 2'd2 ? {led_r[DATA_WIDTH-2:0], led_r[DATA_WIDTH-1]} :
                                       led_r + 1'b1;

    // A trigger on the final pulse cycle reloads, giving back-to-back pulses.
    always_comb begin
        state_nx = state;
        pcnt_nx  = pcnt;
        if (start && (state == IDLE || pcnt == 16'd0)) begin
            state_nx = PULSE;
            pcnt_nx  = bus.cfg_pulse_len - 16'd1;
        end else if (state == PULSE) begin
            state_nx = pcnt == 16'd0 ? IDLE : PULSE;
            pcnt_nx  = pcnt == 16'd0 ? 16'd0 : pcnt - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pcnt  <= '0;
        end else begin
            state <= state_nx;
            pcnt  <= pcnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r    <= '0;
            period_r  <= '0;
            pattern_r <= '0;
            cnt       <= '0;
            led_r     <= '0;
            phase     <= 1'b1;
            trig_d    <= 1'b1;
            tick_r    <= 1'b0;
        end else begin
            trig_d <= bus.trig_in;
            tick_r <= tick & ~bus.cfg_valid;
            if (bus.cfg_valid) begin
                mode_r    <= bus.cfg_mode;
                period_r  <= bus.cfg_period;
                pattern_r <= bus.cfg_pattern;
                cnt       <= '0;
                led_r     <= bus.cfg_pattern;
                phase     <= 1'b1;
            end else begin
                cnt <= tick ? '0 : cnt + 1'b1;
                if (tick) begin
                    led_r <= led_step;
                    phase <= ~phase;
                end
            end
        end
    end

    assign bus.led_out = led_r;
    assign bus.busy    = state == PULSE;
    assign bus.exp_out = {{(DATA_WIDTH-2){1'b0}}, tick_r, state == PULSE};
endmodule

// File: tb/tb_gpio_led_sequencer.sv
// tb_gpio_led_sequencer: directed checks of pattern modes, prescaler timing and the one-shot.
module tb_gpio_led_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    gpio_led_sequencer_if #(.DATA_WIDTH(32), .PRESCALE_WIDTH(32)) bus ();
    gpio_led_sequencer #(.DATA_WIDTH(32), .PRESCALE_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic load(input logic [1:0] m, input logic [31:0] p, input logic [31:0] pat);
        bus.cfg_valid   = 1'b1;
        bus.cfg_mode    = m;
        bus.cfg_period  = p;
        bus.cfg_pattern = pat;
        step();
        bus.cfg_valid   = 1'b0;
    endtask

    initial begin
        logic [31:0] e;
        rst               = 1'b1;
        bus.cfg_valid     = 1'b0;
        bus.cfg_mode      = 2'd0;
        bus.cfg_period    = '0;
        bus.cfg_pattern   = '0;
        bus.cfg_pulse_len = 16'd0;
        bus.trig_in       = 1'b1;
        repeat (3) step();
        chk("rst_led", bus.led_out, 32'h0);
        chk("rst_exp", bus.exp_out, 32'h0);
        chk("rst_busy", {31'b0, bus.busy}, 32'h0);
        rst = 1'b0;
        bus.cfg_pulse_len = 16'd5;
        repeat (100) step();
        chk("idle_led", bus.led_out, 32'h0);
        chk("idle_pulse", {31'b0, bus.exp_out[0]}, 32'h0);
        chk("idle_busy", {31'b0, bus.busy}, 32'h0);
        bus.trig_in = 1'b0;
        step();

        load(2'd2, 32'd3, 32'h1);
        chk("rot_load", bus.led_out, 32'h1);
        e = 32'h1;
        for (int k = 1; k <= 32; k++) begin
            repeat (3) step();
            chk("rot_hold", bus.led_out, e);
            chk("rot_nostrobe", {31'b0, bus.exp_out[1]}, 32'h0);
            step();
            e = {e[30:0], e[31]};
            chk("rot_step", bus.led_out, e);
            chk("rot_strobe", {31'b0, bus.exp_out[1]}, 32'h1);
        end
        chk("rot_wrap", bus.led_out, 32'h1);

        load(2'd3, 32'd0, 32'hFFFF_FFFE);
        chk("cnt_0", bus.led_out, 32'hFFFF_FFFE);
        step();
        chk("cnt_1", bus.led_out, 32'hFFFF_FFFF);
        step();
        chk("cnt_2", bus.led_out, 32'h0);
        step();
        chk("cnt_3", bus.led_out, 32'h1);

        load(2'd1, 32'd1, 32'hA5);
        chk("blk_0", bus.led_out, 32'hA5);
        step(); chk("blk_1", bus.led_out, 32'hA5);
        step(); chk("blk_2", bus.led_out, 32'h00);
        step(); chk("blk_3", bus.led_out, 32'h00);
        step(); chk("blk_4", bus.led_out, 32'hA5);
        step(); chk("blk_5", bus.led_out, 32'hA5);
        step(); chk("blk_6", bus.led_out, 32'h00);
        step(); chk("blk_7", bus.led_out, 32'h00);
        load(2'd1, 32'd1, 32'h3C);
        chk("blk_reload", bus.led_out, 32'h3C);
        step(); chk("blk_r1", bus.led_out, 32'h3C);
        step(); chk("blk_r2", bus.led_out, 32'h00);
        step(); chk("blk_r3", bus.led_out, 32'h00);
        step(); chk("blk_r4", bus.led_out, 32'h3C);

        bus.cfg_pulse_len = 16'd5;
        bus.trig_in = 1'b1;
        step(); chk("p5_c1", {31'b0, bus.exp_out[0]}, 32'h1);
        bus.trig_in = 1'b0;
        step(); chk("p5_c2", {31'b0, bus.busy}, 32'h1);
        bus.trig_in = 1'b1;
        step(); chk("p5_c3", {31'b0, bus.busy}, 32'h1);
        bus.trig_in = 1'b0;
        step(); chk("p5_c4", {31'b0, bus.busy}, 32'h1);
        step(); chk("p5_c5", {31'b0, bus.exp_out[0]}, 32'h1);
        step(); chk("p5_end", {31'b0, bus.busy}, 32'h0);
        chk("p5_end_exp", {31'b0, bus.exp_out[0]}, 32'h0);
        step(); chk("p5_noext", {31'b0, bus.busy}, 32'h0);

        bus.cfg_pulse_len = 16'd0;
        bus.trig_in = 1'b1;
        step(); chk("p0_a", {31'b0, bus.busy}, 32'h0);
        step(); chk("p0_b", {31'b0, bus.exp_out[0]}, 32'h0);
        bus.trig_in = 1'b0;
        step();

        bus.cfg_pulse_len = 16'd2;
        bus.trig_in = 1'b1;
        step(); chk("b2b_1", {31'b0, bus.busy}, 32'h1);
        bus.trig_in = 1'b0;
        step(); chk("b2b_2", {31'b0, bus.busy}, 32'h1);
        bus.trig_in = 1'b1;
        step(); chk("b2b_3", {31'b0, bus.busy}, 32'h1);
        bus.trig_in = 1'b0;
        step(); chk("b2b_4", {31'b0, bus.busy}, 32'h1);
        step(); chk("b2b_end", {31'b0, bus.busy}, 32'h0);

        load(2'd0, 32'd0, 32'h55);
        chk("static", bus.led_out, 32'h55);
        bus.cfg_pulse_len = 16'd10;
        bus.trig_in = 1'b1;
        step(); chk("rp_c1", {31'b0, bus.busy}, 32'h1);
        bus.trig_in = 1'b0;
        step(); chk("rp_c2", {31'b0, bus.busy}, 32'h1);
        rst = 1'b1;
        step();
        chk("rp_busy", {31'b0, bus.busy}, 32'h0);
        chk("rp_exp", bus.exp_out, 32'h0);
        chk("rp_led", bus.led_out, 32'h0);
        rst = 1'b0;
        repeat (3) step();
        chk("rp_after", {31'b0, bus.busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
